vga_console_ctrl: RTL and testbench
===================================

// Module: vga_console_ctrl
// PURPOSE
//  Text-console sequencer for the 80x60 VGA character RAM. Accepts ASCII from the CPU over a valid/ready
//  handshake, tracks the cursor, and issues char-RAM writes. Handles CR/LF/BS/FF, line wrap, scroll-up
//  (row copy) and clear-screen. Sits between the CPU I/O store path and the char-RAM write/read port.
// PARAMETERS
//  COLS    80  characters per row
//  ROWS    60  character rows
//  AW      13  char-RAM address width (COLS*ROWS <= 2**AW)
//  CW      7   character code width
//  BLANK   7'h20  fill code for clear/scroll/backspace
// PORTS
//  sys_clk    in   1   system clock, 50MHz
//  clr        in   1   asynchronous, active-high reset
//  ch_valid   in   1   CPU offers character
//  ch_data    in   CW  character code
//  ch_ready   out  1   controller accepts; transfer = ch_valid & ch_ready
//  cls        in   1   clear-screen request, level sampled in IDLE
//  ram_addr   out  AW  char-RAM address, row*COLS+col
//  ram_we     out  1   char-RAM write enable
//  ram_wdata  out  CW  char-RAM write data
//  ram_rdata  in   CW  char-RAM read data; sync read, valid the cycle after ram_addr
//  cur_row    out  6   cursor row 0..ROWS-1
//  cur_col    out  7   cursor col 0..COLS-1
//  busy       out  1   high in any state other than IDLE
// BEHAVIOUR
//  Reset: state=CLR_ALL, cnt=0, cur_row=0, cur_col=0, ram_we=0, ram_addr=0, ram_wdata=BLANK, ch_ready=0, busy=1.
//  States: IDLE, PUT, SC_RD, SC_WR, CLR_LINE, CLR_ALL.
//  ch_ready = (state==IDLE) & ~cls. cls wins over ch_valid in the same cycle; char is not accepted.
//  IDLE & cls -> CLR_ALL. IDLE & transfer: decode ch_data.
//   0x20..0x7E: PUT writes char at cursor (1 cycle, ram_we=1). col<COLS-1: col++.
//     col==COLS-1: col=0, row++. If row==ROWS-1: row stays, -> SC_RD.
//   0x0A LF: col=0. row<ROWS-1: row++, stay IDLE. Else -> SC_RD.
//   0x0D CR: col=0, no write.
//   0x08 BS: col>0: col--, PUT writes BLANK at new cursor. col==0: no-op, no row crossing.
//   0x0C FF: same as cls. Any other code: accepted, discarded.
//  Throughput: printable char = 2 cycles (accept, PUT); CR/LF/ignored = 1 cycle.
//  Scroll: cnt a = 0..COLS*(ROWS-1)-1. SC_RD presents ram_addr=a+COLS, we=0. SC_WR presents ram_addr=a,
//   we=1, ram_wdata=ram_rdata (combinational pass-through). Other states: ram_wdata is registered.
//   After last cell -> CLR_LINE: BLANK written to row ROWS-1, 1 cell/cycle, then IDLE.
//   Total 2*4720+80 = 9520 busy cycles.
//  CLR_ALL: BLANK to addr 0..COLS*ROWS-1, 1/cycle (4800 cycles). Cursor=(0,0) on entry. Then IDLE.
//  Address: row*COLS+col computed as (row<<6)+(row<<4)+col for COLS=80, else multiply. No address ever
//   >= COLS*ROWS.
//  Reset asserted mid-scroll/clear aborts immediately to reset state; RAM contents are undefined until the
//   new CLR_ALL completes.
//  cls/ch_valid while busy: ignored, not queued. CPU holds ch_valid until ready.
// STRUCTURE
//  Shared package vga_pkg: COLS, ROWS, AW, CW, BLANK, control codes (CH_BS, CH_LF, CH_FF, CH_CR),
//   state encoding typedef.
//  One sub-module, vga_addr_calc (row,col -> addr); the FSM and counters stay in this module.
// TESTING
//  Reset release -> busy for 4800 cycles, ram_we=1 on addrs 0..4799 with BLANK, then ch_ready=1, cursor (0,0).
//  Send 'A','B' -> writes 0x41@0, 0x42@1, cursor (0,2); ch_ready low in each PUT cycle.
//  Cursor (5,79), send 'Z' -> write 0x5A@479, cursor (6,0). BS at (6,0) -> no write.
//   BS at (6,3) -> BLANK@482, cursor (6,2).
//  Cursor (59,10), send LF -> 9520 busy cycles; model RAM row r == old row r+1; row 59 all BLANK; cursor (59,0).
//  cls and ch_valid both high in IDLE -> char not accepted, CLR_ALL runs; FF code gives identical result.
//  clr pulsed at scroll cell 1000 -> outputs at reset values same cycle; clean CLR_ALL follows.

Source files
------------

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pkg
//  Description : Shared constants, control codes and state encoding for the
//                80x60 VGA text-console controller.
//  Contents    : geometry (COLS, ROWS), widths (AW, CW, RW, CLW), fill code
//                BLANK, ASCII control codes, FSM state typedef.
//  Revision    : 1.0  initial release
// ============================================================================
package vga_pkg;

  localparam int COLS = 80;                  // characters per row
  localparam int ROWS = 60;                  // character rows
  localparam int AW   = 13;                  // char-RAM address width
  localparam int CW   = 7;                   // character code width
  localparam int RW   = 6;                   // cursor row width
  localparam int CLW  = 7;                   // cursor column width

  localparam int CELLS        = COLS * ROWS;        // whole screen
  localparam int SCROLL_CELLS = COLS * (ROWS - 1);  // cells moved by a scroll

  localparam logic [CW-1:0] BLANK    = 7'h20;
  localparam logic [CW-1:0] CH_BS    = 7'h08;
  localparam logic [CW-1:0] CH_LF    = 7'h0A;
  localparam logic [CW-1:0] CH_FF    = 7'h0C;
  localparam logic [CW-1:0] CH_CR    = 7'h0D;
  localparam logic [CW-1:0] CH_PR_LO = 7'h20;  // first printable code
  localparam logic [CW-1:0] CH_PR_HI = 7'h7E;  // last printable code

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PUT      = 3'd1,
    ST_SC_RD    = 3'd2,
    ST_SC_WR    = 3'd3,
    ST_CLR_LINE = 3'd4,
    ST_CLR_ALL  = 3'd5
  } state_t;

endpackage : vga_pkg
`default_nettype wire

// File: rtl/vga_addr_calc.sv
`default_nettype none
// ============================================================================
//  Module      : vga_addr_calc
//  Description : Converts a (row, col) character position into the linear
//                char-RAM address row*COLS+col.
//  Ports       : row  in  RW   character row
//                col  in  CLW  character column
//                addr out AW   linear char-RAM address
//  Revision    : 1.0  initial release
// ============================================================================
module vga_addr_calc
  import vga_pkg::*;
(
  input  logic [RW-1:0]  row,
  input  logic [CLW-1:0] col,
  output logic [AW-1:0]  addr
);

  logic [AW-1:0] w_row_ext;
  logic [AW-1:0] w_col_ext;

  assign w_row_ext = AW'(row);
  assign w_col_ext = AW'(col);

  generate
    if (COLS == 80) begin : g_shift_add
      // 80 = 64 + 16, so two shifted copies replace the multiplier.
      assign addr = (w_row_ext << 6) + (w_row_ext << 4) + w_col_ext;
    end else begin : g_mult
      assign addr = (w_row_ext * AW'(COLS)) + w_col_ext;
    end
  endgenerate

endmodule : vga_addr_calc
`default_nettype wire

// File: rtl/vga_console_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : vga_console_ctrl
//  Description : Text-console sequencer for the 80x60 character RAM. Takes
//                ASCII over valid/ready, tracks the cursor, writes the RAM,
//                and handles CR/LF/BS/FF, line wrap, scroll-up and clear.
//  Ports       : sys_clk   in   system clock
//                clr       in   asynchronous active-high reset
//                ch_valid  in   CPU offers a character
//                ch_data   in   character code
//                ch_ready  out  controller accepts the character
//                cls       in   clear-screen request (sampled in IDLE)
//                ram_addr  out  char-RAM address
//                ram_we    out  char-RAM write enable
//                ram_wdata out  char-RAM write data
//                ram_rdata in   char-RAM read data (one cycle after address)
//                cur_row   out  cursor row
//                cur_col   out  cursor column
//                busy      out  high whenever not IDLE
//  Revision    : 1.0  initial release
// ============================================================================
module vga_console_ctrl
  import vga_pkg::*;
(
  input  logic           sys_clk,
  input  logic           clr,
  input  logic           ch_valid,
  input  logic [CW-1:0]  ch_data,
  output logic           ch_ready,
  input  logic           cls,
  output logic [AW-1:0]  ram_addr,
  output logic           ram_we,
  output logic [CW-1:0]  ram_wdata,
  input  logic [CW-1:0]  ram_rdata,
  output logic [RW-1:0]  cur_row,
  output logic [CLW-1:0] cur_col,
  output logic           busy
);

  localparam logic [AW-1:0]  c_last_cell   = AW'(CELLS - 1);
  localparam logic [AW-1:0]  c_last_scroll = AW'(SCROLL_CELLS - 1);
  localparam logic [AW-1:0]  c_cols        = AW'(COLS);
  localparam logic [AW-1:0]  c_last_col_aw = AW'(COLS - 1);
  localparam logic [CLW-1:0] c_last_col    = CLW'(COLS - 1);
  localparam logic [RW-1:0]  c_last_row    = RW'(ROWS - 1);

  state_t         r_state,   w_state_nxt;
  logic [AW-1:0]  r_cnt,     w_cnt_nxt;
  logic [RW-1:0]  r_row,     w_row_nxt;
  logic [CLW-1:0] r_col,     w_col_nxt;
  logic [CW-1:0]  r_wdata,   w_wdata_nxt;
  logic           r_advance, w_advance_nxt;   // PUT moves the cursor (not BS)

  logic [RW-1:0]  w_calc_row;
  logic [CLW-1:0] w_calc_col;
  logic [AW-1:0]  w_cell_addr;
  logic           w_printable;
  logic           w_clear_req;

  // The address calculator serves the cursor position normally and walks
  // the bottom row while that row is being blanked after a scroll.
  assign w_calc_row = (r_state == ST_CLR_LINE) ? c_last_row : r_row;
  assign w_calc_col = (r_state == ST_CLR_LINE) ? r_cnt[CLW-1:0] : r_col;

  vga_addr_calc u_addr_calc (
    .row  (w_calc_row),
    .col  (w_calc_col),
    .addr (w_cell_addr)
  );

  assign w_printable = (ch_data >= CH_PR_LO) && (ch_data <= CH_PR_HI);
  // cls has priority; an FF character is handled exactly like cls.
  assign w_clear_req = cls || (ch_valid && (ch_data == CH_FF));

  assign cur_row = r_row;
  assign cur_col = r_col;

  always_ff @(posedge sys_clk or posedge clr) begin
    if (clr) begin
      r_state   <= ST_CLR_ALL;
      r_cnt     <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_wdata   <= BLANK;
      r_advance <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_row     <= w_row_nxt;
      r_col     <= w_col_nxt;
      r_wdata   <= w_wdata_nxt;
      r_advance <= w_advance_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_row_nxt     = r_row;
    w_col_nxt     = r_col;
    w_wdata_nxt   = r_wdata;
    w_advance_nxt = r_advance;
    ch_ready      = (r_state == ST_IDLE) && !cls;
    busy          = (r_state != ST_IDLE);
    ram_we        = 1'b0;
    ram_addr      = w_cell_addr;
    ram_wdata     = r_wdata;

    case (r_state)
      ST_IDLE: begin
        if (w_clear_req) begin
          w_state_nxt = ST_CLR_ALL;
          w_cnt_nxt   = '0;
          w_row_nxt   = '0;
          w_col_nxt   = '0;
          w_wdata_nxt = BLANK;
        end else if (ch_valid) begin
          if (w_printable) begin
            w_wdata_nxt   = ch_data;
            w_advance_nxt = 1'b1;
            w_state_nxt   = ST_PUT;
          end else if (ch_data == CH_LF) begin
            w_col_nxt = '0;
            if (r_row != c_last_row) begin
              w_row_nxt = r_row + 1'b1;
            end else begin
              w_state_nxt = ST_SC_RD;
              w_cnt_nxt   = '0;
              w_wdata_nxt = BLANK;
            end
          end else if (ch_data == CH_CR) begin
            w_col_nxt = '0;
          end else if (ch_data == CH_BS) begin
            // Backspace never crosses back into the previous row.
            if (r_col != '0) begin
              w_col_nxt     = r_col - 1'b1;
              w_wdata_nxt   = BLANK;
              w_advance_nxt = 1'b0;
              w_state_nxt   = ST_PUT;
            end
          end
        end
      end

      ST_PUT: begin
        ram_we      = 1'b1;
        w_state_nxt = ST_IDLE;
        if (r_advance) begin
          if (r_col != c_last_col) begin
            w_col_nxt = r_col + 1'b1;
          end else begin
            w_col_nxt = '0;
            if (r_row != c_last_row) begin
              w_row_nxt = r_row + 1'b1;
            end else begin
              w_state_nxt = ST_SC_RD;
              w_cnt_nxt   = '0;
              w_wdata_nxt = BLANK;
            end
          end
        end
      end

      ST_SC_RD: begin
        ram_addr    = r_cnt + c_cols;
        w_state_nxt = ST_SC_WR;
      end

      ST_SC_WR: begin
        // Read data for the cell one row below arrives this cycle.
        ram_we    = 1'b1;
        ram_addr  = r_cnt;
        ram_wdata = ram_rdata;
        if (r_cnt == c_last_scroll) begin
          w_state_nxt = ST_CLR_LINE;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = ST_SC_RD;
          w_cnt_nxt   = r_cnt + 1'b1;
        end
      end

      ST_CLR_LINE: begin
        ram_we = 1'b1;
        if (r_cnt == c_last_col_aw) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      ST_CLR_ALL: begin
        // Suppressed while clr is held so the port shows its reset values.
        ram_we   = !clr;
        ram_addr = r_cnt;
        if (r_cnt == c_last_cell) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule : vga_console_ctrl
`default_nettype wire

// File: tb/tb_vga_console_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_console_ctrl
//  Description : Directed self-checking bench for vga_console_ctrl with a
//                behavioural char RAM (synchronous read, read-first).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vga_console_ctrl;
  import vga_pkg::*;

  logic           sys_clk  = 1'b0;
  logic           clr      = 1'b1;
  logic           ch_valid = 1'b0;
  logic [CW-1:0]  ch_data  = '0;
  logic           cls      = 1'b0;
  logic           ch_ready;
  logic [AW-1:0]  ram_addr;
  logic           ram_we;
  logic [CW-1:0]  ram_wdata;
  logic [CW-1:0]  ram_rdata;
  logic [RW-1:0]  cur_row;
  logic [CLW-1:0] cur_col;
  logic           busy;

  int n_cmp    = 0;
  int n_fail   = 0;
  int bad_addr = 0;

  logic [CW-1:0] mem     [0:8191];
  logic [CW-1:0] exp_mem [0:CELLS-1];
  logic          preload = 1'b0;

  vga_console_ctrl dut (
    .sys_clk   (sys_clk),
    .clr       (clr),
    .ch_valid  (ch_valid),
    .ch_data   (ch_data),
    .ch_ready  (ch_ready),
    .cls       (cls),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .cur_row   (cur_row),
    .cur_col   (cur_col),
    .busy      (busy)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [CW-1:0] pat(input int i);
    return 7'((i * 37 + 11) % 97 + 1);
  endfunction

  always @(posedge sys_clk) begin
    if (preload) begin
      for (int i = 0; i < CELLS; i++) mem[i] <= pat(i);
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  always @(negedge sys_clk) begin
    if (ram_we && (ram_addr >= 13'd4800)) bad_addr <= bad_addr + 1;
  end

  function automatic int count_nonblank();
    int e = 0;
    for (int i = 0; i < CELLS; i++) if (mem[i] !== BLANK) e++;
    return e;
  endfunction

  // Offer one character (called at a negedge); returns at the negedge
  // following the accepting clock edge.
  task automatic send(input logic [CW-1:0] c);
    int n = 0;
    ch_valid = 1'b1;
    ch_data  = c;
    while (!ch_ready && n < 20000) begin @(negedge sys_clk); n++; end
    if (n >= 20000) begin
      n_cmp++; n_fail++;
      $display("FAIL send_timeout: ch_ready=%0b want 1", ch_ready);
    end
    @(negedge sys_clk);
    ch_valid = 1'b0;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy && cycles < 20000) begin cycles++; @(negedge sys_clk); end
  endtask

  // Releases clr and checks the full-screen blanking sweep that follows.
  task automatic release_and_check_clear(input string tag);
    int n = 0, seq_err = 0;
    clr = 1'b0;
    #1;
    while (busy && n < 10000) begin
      if (!(ram_we === 1'b1 && ram_addr === 13'(n) && ram_wdata === BLANK)) seq_err++;
      n++;
      @(negedge sys_clk);
    end
    n_cmp++; if (n != 4800) begin n_fail++; $display("FAIL %s_busy_cycles: got %0d want 4800", tag, n); end
    n_cmp++; if (seq_err != 0) begin n_fail++; $display("FAIL %s_write_seq: got %0d bad cycles want 0", tag, seq_err); end
    n_cmp++; if (count_nonblank() != 0) begin n_fail++; $display("FAIL %s_ram_blank: got %0d nonblank want 0", tag, count_nonblank()); end
    n_cmp++; if (ch_ready !== 1'b1) begin n_fail++; $display("FAIL %s_ready: got %0b want 1", tag, ch_ready); end
    n_cmp++; if (cur_row !== 6'd0 || cur_col !== 7'd0) begin n_fail++; $display("FAIL %s_cursor: got (%0d,%0d) want (0,0)", tag, cur_row, cur_col); end
  endtask

  task automatic test_reset();
    @(negedge sys_clk);
    @(negedge sys_clk);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy: got %0b want 1", busy); end
    n_cmp++; if (ch_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %0b want 0", ch_ready); end
    n_cmp++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %0b want 0", ram_we); end
    n_cmp++; if (ram_addr !== 13'd0) begin n_fail++; $display("FAIL rst_addr: got %0d want 0", ram_addr); end
    n_cmp++; if (ram_wdata !== 7'h20) begin n_fail++; $display("FAIL rst_wdata: got %h want 20", ram_wdata); end
    n_cmp++; if (cur_row !== 6'd0 || cur_col !== 7'd0) begin n_fail++; $display("FAIL rst_cursor: got (%0d,%0d) want (0,0)", cur_row, cur_col); end
    release_and_check_clear("init");
  endtask

  task automatic test_put_ab();
    send(7'h41);
    n_cmp++; if (ram_we !== 1'b1 || ram_addr !== 13'd0 || ram_wdata !== 7'h41) begin n_fail++; $display("FAIL put_a: got we=%0b addr=%0d data=%h want 1/0/41", ram_we, ram_addr, ram_wdata); end
    n_cmp++; if (ch_ready !== 1'b0) begin n_fail++; $display("FAIL put_a_ready: got %0b want 0", ch_ready); end
    send(7'h42);
    n_cmp++; if (ram_we !== 1'b1 || ram_addr !== 13'd1 || ram_wdata !== 7'h42) begin n_fail++; $display("FAIL put_b: got we=%0b addr=%0d data=%h want 1/1/42", ram_we, ram_addr, ram_wdata); end
    n_cmp++; if (ch_ready !== 1'b0) begin n_fail++; $display("FAIL put_b_ready: got %0b want 0", ch_ready); end
    @(negedge sys_clk);
    n_cmp++; if (cur_row !== 6'd0 || cur_col !== 7'd2) begin n_fail++; $display("FAIL put_cursor: got (%0d,%0d) want (0,2)", cur_row, cur_col); end
    n_cmp++; if (mem[0] !== 7'h41 || mem[1] !== 7'h42) begin n_fail++; $display("FAIL put_ram: got %h %h want 41 42", mem[0], mem[1]); end
  endtask

  task automatic test_wrap_bs();
    send(CH_CR);
    n_cmp++; if (cur_col !== 7'd0 || ram_we !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL cr: got col=%0d we=%0b busy=%0b want 0/0/0", cur_col, ram_we, busy); end
    for (int i = 0; i < 5; i++) send(CH_LF);
    for (int i = 0; i < 79; i++) send(7'h78);
    @(negedge sys_clk);
    n_cmp++; if (cur_row !== 6'd5 || cur_col !== 7'd79) begin n_fail++; $display("FAIL pos_5_79: got (%0d,%0d) want (5,79)", cur_row, cur_col); end
    send(7'h5A);
    n_cmp++; if (ram_we !== 1'b1 || ram_addr !== 13'd479 || ram_wdata !== 7'h5A) begin n_fail++; $display("FAIL wrap_put: got we=%0b addr=%0d data=%h want 1/479/5a", ram_we, ram_addr, ram_wdata); end
    @(negedge sys_clk);
    n_cmp++; if (cur_row !== 6'd6 || cur_col !== 7'd0) begin n_fail++; $display("FAIL wrap_cursor: got (%0d,%0d) want (6,0)", cur_row, cur_col); end
    send(CH_BS);
    n_cmp++; if (ram_we !== 1'b0 || busy !== 1'b0 || cur_row !== 6'd6 || cur_col !== 7'd0) begin n_fail++; $display("FAIL bs_col0: got we=%0b busy=%0b (%0d,%0d) want 0/0/(6,0)", ram_we, busy, cur_row, cur_col); end
    for (int i = 0; i < 3; i++) send(7'h63);
    @(negedge sys_clk);
    send(CH_BS);
    n_cmp++; if (ram_we !== 1'b1 || ram_addr !== 13'd482 || ram_wdata !== BLANK) begin n_fail++; $display("FAIL bs_put: got we=%0b addr=%0d data=%h want 1/482/20", ram_we, ram_addr, ram_wdata); end
    @(negedge sys_clk);
    n_cmp++; if (cur_row !== 6'd6 || cur_col !== 7'd2 || mem[482] !== BLANK || mem[479] !== 7'h5A) begin n_fail++; $display("FAIL bs_result: got (%0d,%0d) m482=%h m479=%h want (6,2) 20 5a", cur_row, cur_col, mem[482], mem[479]); end
    send(7'h01);
    n_cmp++; if (busy !== 1'b0 || ram_we !== 1'b0 || cur_col !== 7'd2) begin n_fail++; $display("FAIL ignored: got busy=%0b we=%0b col=%0d want 0/0/2", busy, ram_we, cur_col); end
  endtask

  task automatic test_scroll();
    int n, errs, row_errs;
    send(CH_CR);
    for (int i = 0; i < 53; i++) send(CH_LF);
    for (int i = 0; i < 10; i++) send(7'h6B);
    @(negedge sys_clk);
    n_cmp++; if (cur_row !== 6'd59 || cur_col !== 7'd10) begin n_fail++; $display("FAIL pos_59_10: got (%0d,%0d) want (59,10)", cur_row, cur_col); end
    preload = 1'b1;
    @(negedge sys_clk);
    preload = 1'b0;
    for (int i = 0; i < CELLS; i++) exp_mem[i] = (i < SCROLL_CELLS) ? pat(i + COLS) : BLANK;
    send(CH_LF);
    wait_idle(n);
    n_cmp++; if (n != 9520) begin n_fail++; $display("FAIL scroll_cycles: got %0d want 9520", n); end
    errs = 0; row_errs = 0;
    for (int i = 0; i < CELLS; i++) if (mem[i] !== exp_mem[i]) errs++;
    for (int i = SCROLL_CELLS; i < CELLS; i++) if (mem[i] !== BLANK) row_errs++;
    n_cmp++; if (errs != 0) begin n_fail++; $display("FAIL scroll_ram: got %0d wrong cells want 0", errs); end
    n_cmp++; if (row_errs != 0) begin n_fail++; $display("FAIL scroll_row59: got %0d nonblank want 0", row_errs); end
    n_cmp++; if (cur_row !== 6'd59 || cur_col !== 7'd0) begin n_fail++; $display("FAIL scroll_cursor: got (%0d,%0d) want (59,0)", cur_row, cur_col); end
    n_cmp++; if (bad_addr != 0) begin n_fail++; $display("FAIL addr_range: got %0d out-of-range writes want 0", bad_addr); end
  endtask

  task automatic test_cls();
    int n;
    send(7'h71);
    @(negedge sys_clk);
    n_cmp++; if (cur_row !== 6'd59 || cur_col !== 7'd1) begin n_fail++; $display("FAIL pos_59_1: got (%0d,%0d) want (59,1)", cur_row, cur_col); end
    cls = 1'b1; ch_valid = 1'b1; ch_data = 7'h4B;
    #1;
    n_cmp++; if (ch_ready !== 1'b0) begin n_fail++; $display("FAIL cls_ready: got %0b want 0", ch_ready); end
    @(negedge sys_clk);
    cls = 1'b0; ch_valid = 1'b0;
    n_cmp++; if (busy !== 1'b1 || cur_row !== 6'd0 || cur_col !== 7'd0 || ram_we !== 1'b1 || ram_addr !== 13'd0) begin n_fail++; $display("FAIL cls_start: got busy=%0b (%0d,%0d) we=%0b addr=%0d want 1 (0,0) 1 0", busy, cur_row, cur_col, ram_we, ram_addr); end
    wait_idle(n);
    n_cmp++; if (n != 4800) begin n_fail++; $display("FAIL cls_cycles: got %0d want 4800", n); end
    n_cmp++; if (count_nonblank() != 0 || cur_col !== 7'd0) begin n_fail++; $display("FAIL cls_result: got %0d nonblank col=%0d want 0 0", count_nonblank(), cur_col); end
  endtask

  task automatic test_ff();
    int n;
    send(7'h61);
    send(7'h62);
    @(negedge sys_clk);
    n_cmp++; if (cur_col !== 7'd2) begin n_fail++; $display("FAIL ff_pre: got col=%0d want 2", cur_col); end
    send(CH_FF);
    n_cmp++; if (busy !== 1'b1 || cur_row !== 6'd0 || cur_col !== 7'd0) begin n_fail++; $display("FAIL ff_start: got busy=%0b (%0d,%0d) want 1 (0,0)", busy, cur_row, cur_col); end
    wait_idle(n);
    n_cmp++; if (n != 4800) begin n_fail++; $display("FAIL ff_cycles: got %0d want 4800", n); end
    n_cmp++; if (count_nonblank() != 0) begin n_fail++; $display("FAIL ff_ram: got %0d nonblank want 0", count_nonblank()); end
  endtask

  task automatic test_reset_mid_scroll();
    int n = 0;
    for (int i = 0; i < 60; i++) send(CH_LF);
    while (!(ram_we === 1'b1 && ram_addr === 13'd1000) && n < 20000) begin @(negedge sys_clk); n++; end
    n_cmp++; if (n >= 20000) begin n_fail++; $display("FAIL mid_find: got timeout want cell 1000 write"); end
    clr = 1'b1;
    #1;
    n_cmp++; if (ram_we !== 1'b0 || ram_addr !== 13'd0 || ram_wdata !== BLANK) begin n_fail++; $display("FAIL mid_rst_ram: got we=%0b addr=%0d data=%h want 0/0/20", ram_we, ram_addr, ram_wdata); end
    n_cmp++; if (busy !== 1'b1 || ch_ready !== 1'b0 || cur_row !== 6'd0 || cur_col !== 7'd0) begin n_fail++; $display("FAIL mid_rst_ctl: got busy=%0b rdy=%0b (%0d,%0d) want 1 0 (0,0)", busy, ch_ready, cur_row, cur_col); end
    @(negedge sys_clk);
    release_and_check_clear("mid");
    n_cmp++; if (bad_addr != 0) begin n_fail++; $display("FAIL addr_range_end: got %0d out-of-range writes want 0", bad_addr); end
  endtask

  initial begin
    test_reset();
    test_put_ab();
    test_wrap_bs();
    test_scroll();
    test_cls();
    test_ff();
    test_reset_mid_scroll();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_vga_console_ctrl
`default_nettype wire
